// File: rtl/bsg_n_to_1_tagged_rr.sv
// Round-robin N-to-1 concentrator with a single-entry tagged output buffer.
// Optional transfer counter on count_o when BSG_N_TO_1_TAGGED_COUNT_EN is defined.
module bsg_n_to_1_tagged_rr #(
    parameter  int num_in_p     = 32,
    parameter  int width_p      = 8,
    localparam int tag_width_lp = (num_in_p > 1) ? $clog2(num_in_p) : 1
) (
    input  logic                        clk_i,
    input  logic                        reset_n_i,
    input  logic [num_in_p-1:0]         v_i,
    input  logic [num_in_p*width_p-1:0] data_i,
    output logic [num_in_p-1:0]         yumi_o,
    output logic                        v_o,
    output logic [width_p-1:0]          data_o,
    output logic [tag_width_lp-1:0]     tag_o,
    input  logic                        ready_i
`ifdef BSG_N_TO_1_TAGGED_COUNT_EN
    ,
    output logic [15:0]                 count_o
`endif
);

    logic [tag_width_lp-1:0] last_r;
    logic [tag_width_lp-1:0] grant_idx;
    logic [tag_width_lp:0]   scan_idx;
    logic                    grant_found;
    logic                    load_en;
    logic                    grant;
    logic [width_p-1:0]      grant_data;

    assign load_en = ~v_o | ready_i;

    // Scan starts one past the last winner; last_r itself is tried last.
    always_comb begin
        grant_found = 1'b0;
        grant_idx   = last_r;
        scan_idx    = '0;
        for (int unsigned i = 1; i <= num_in_p; i++) begin
            scan_idx = {1'b0, last_r} + (tag_width_lp + 1)'(i);
            if (scan_idx >= (tag_width_lp + 1)'(num_in_p))
                scan_idx = scan_idx - (tag_width_lp + 1)'(num_in_p);
            if (!grant_found && v_i[scan_idx[tag_width_lp-1:0]]) begin
                grant_found = 1'b1;
                grant_idx   = scan_idx[tag_width_lp-1:0];
            end
        end
    end

    assign grant = reset_n_i & grant_found & load_en;

    always_comb begin
        yumi_o = '0;
        if (grant)
            yumi_o[grant_idx] = 1'b1;
    end

    always_comb begin
        grant_data = '0;
        for (int unsigned k = 0; k < num_in_p; k++) begin
            if (tag_width_lp'(k) == grant_idx)
                grant_data = data_i[k*width_p +: width_p];
        end
    end

    always_ff @(posedge clk_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            v_o    <= 1'b0;
            data_o <= '0;
            tag_o  <= '0;
            last_r <= tag_width_lp'(num_in_p - 1);
        end else if (grant) begin
            v_o    <= 1'b1;
            data_o <= grant_data;
            tag_o  <= grant_idx;
            last_r <= grant_idx;
        end else if (ready_i) begin
            v_o    <= 1'b0;
        end
    end

`ifdef BSG_N_TO_1_TAGGED_COUNT_EN
    always_ff @(posedge clk_i or negedge reset_n_i) begin
        if (!reset_n_i)
            count_o <= '0;
        else if (v_o && ready_i && (count_o != 16'hFFFF))
            count_o <= count_o + 16'd1;
    end
`endif

endmodule

// File: doc/bsg_n_to_1_tagged_rr.md
BSG_N_TO_1_TAGGED_RR -- requirements
Module: bsg_n_to_1_tagged_rr

Interface
REQ-001 The block SHALL have parameter num_in_p, default 32, giving the number of input channels (2..64).
REQ-002 The block SHALL have parameter width_p, default 8, giving the payload width per channel.
REQ-003 The block SHALL derive tag_width_lp = ceil(log2(num_in_p)), which is 5 at default.
REQ-004 The block SHALL have one clock and an asynchronous, active-low reset, with these ports:
- clk_i  input  1  clock; all state changes on the rising edge.
- reset_n_i  input  1  asynchronous, active-low reset.
REQ-005 The block SHALL have these data ports:
- v_i  input  num_in_p  per-channel valid.
- data_i  input  num_in_p*width_p  per-channel payload; channel k is bits [k*width_p +: width_p].
- yumi_o  output  num_in_p  one-hot consume strobe to the winning channel.
- v_o  output  1  output buffer holds an entry.
- data_o  output  width_p  payload of the buffered entry.
- tag_o  output  tag_width_lp  index of the channel that sourced the buffered entry.
- ready_i  input  1  downstream accepts the entry when v_o & ready_i.
REQ-006 When BSG_N_TO_1_TAGGED_COUNT_EN is defined, the block SHALL have the additional port count_o  output  16  number of accepted output transfers.

Function
REQ-007 The block SHALL hold a single-entry output buffer (valid, data, tag) that drives v_o, data_o and tag_o directly from flops.
REQ-008 The buffer SHALL be able to load when it is empty (load_en = ~v_o | ready_i).
REQ-009 The arbiter SHALL grant the first asserted v_i at or above index last_r+1, wrapping modulo num_in_p, where last_r is the most recently granted index.
REQ-010 yumi_o[k] SHALL be asserted combinationally iff channel k is granted, any v_i is asserted, and load_en is true; at most one bit SHALL be set.
REQ-011 yumi_o SHALL depend only on v_i, v_o, ready_i and state, and never on data_i.
REQ-012 On a grant, the buffer SHALL capture data_i[k], tag k, and valid=1 at the next edge, and last_r SHALL become k; latency from input to v_o is 1 cycle.
REQ-013 On v_o & ready_i with no grant in the same cycle, the buffer valid SHALL clear at the next edge.
REQ-014 When a transfer out and a grant occur in the same cycle, the buffer SHALL be replaced with the new entry and valid SHALL stay 1, so that full throughput is 1 transfer per cycle.
REQ-015 When v_o=1 and ready_i=0, the buffer SHALL hold data_o and tag_o stable, and yumi_o SHALL be all zeros.
REQ-016 last_r SHALL be unchanged in cycles with no grant.
REQ-017 When only one channel is valid, that channel SHALL win on consecutive cycles; wrap-around SHALL be handled as follows:
- last_r = num_in_p-1 searches from index 0.
- last_r = k with only v_i[k] set re-grants k.
REQ-018 An input that is valid SHALL be granted within num_in_p grants.

Reset
REQ-019 Reset assertion SHALL asynchronously force v_o=0 and last_r=num_in_p-1, so that the first search starts at channel 0.
REQ-020 While reset is asserted, yumi_o SHALL be all zeros.
REQ-021 While reset is asserted, data_o and tag_o SHALL be 0.
REQ-022 Reset mid-transfer SHALL discard the buffered entry with no partial output.
REQ-023 Reset deassertion SHALL be used synchronized externally, and the first grant SHALL be possible in the first cycle after deassertion.

Configuration
REQ-024 The macro BSG_N_TO_1_TAGGED_COUNT_EN SHALL control the transfer counter:
- When defined, count_o SHALL increment by 1 on each cycle with v_o & ready_i.
- count_o SHALL saturate at 16'hFFFF.
- count_o SHALL reset to 0.
- When undefined, the port and the counter logic SHALL be absent, and all other behaviour SHALL be identical.

Verification
REQ-025 The bench SHALL cover reset, then v_i=32'h1, data_i[0]=8'hA5, ready_i=1 -> yumi_o=32'h1 in cycle 0, then v_o=1, data_o=8'hA5, tag_o=0 in cycle 1.
REQ-026 The bench SHALL cover v_i=32'hFFFFFFFF held and ready_i=1 for 34 cycles -> tag_o sequence 0,1,...,31,0,1, with one transfer per cycle.
REQ-027 The bench SHALL cover buffer full with ready_i=0 for 5 cycles -> yumi_o=0, and data_o/tag_o stable; then ready_i=1 -> the next channel loads in the same cycle and v_o stays 1.
REQ-028 The bench SHALL cover last_r=31 with v_i=32'h80000001 -> channel 0 granted, then channel 31 next.
REQ-029 The bench SHALL cover reset_n_i pulsed low mid-clock with v_o=1 -> v_o=0 immediately without waiting for a clock edge, and after release the first grant is the lowest valid index.
REQ-030 With COUNT_EN defined, the bench SHALL cover 70000 accepted transfers -> count_o=16'hFFFF, held at that value.
